// File: rtl/ntt_loader_pkg.sv
// Shared types for the NTT stream loader: controller states and op_mode encodings.
package ntt_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StWait,
    StFetch,
    StCapt,
    StEmit,
    StFin
  } state_e;

  localparam logic [1:0] MODE_NOP    = 2'b00;
  localparam logic [1:0] MODE_LOAD   = 2'b01;
  localparam logic [1:0] MODE_UNLOAD = 2'b10;
  localparam logic [1:0] MODE_FULL   = 2'b11;

endpackage

// File: rtl/ntt_row_buffer.sv
// Holds one row read from all banks at once and presents a single column of it.
module ntt_row_buffer #(
  parameter int unsigned D_WIDTH = 17,
  parameter int unsigned BN      = 16,
  localparam int unsigned CBW    = $clog2(BN)
) (
  input  logic                  clk,
  input  logic                  capt_i,
  input  logic [BN*D_WIDTH-1:0] rdata_i,
  input  logic [CBW-1:0]        col_i,
  output logic [D_WIDTH-1:0]    data_o
);

  logic [D_WIDTH-1:0] row_q [BN];

  // Contents are only meaningful after a capture, so no reset is needed.
  always_ff @(posedge clk) begin
    if (capt_i) begin
      for (int b = 0; b < BN; b++) begin
        row_q[b] <= rdata_i[b*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign data_o = row_q[col_i];

endmodule

// File: rtl/ntt_stream_loader.sv
// Streams coefficients into the banked memory, kicks the NTT core, and streams the
// banked result back out in natural index order (index = row*BN + col).
module ntt_stream_loader
  import ntt_loader_pkg::*;
#(
  parameter int unsigned D_WIDTH = 17,
  parameter int unsigned BN      = 16,
  parameter int unsigned DEGREE  = 256,
  localparam int unsigned MA     = DEGREE / BN,
  localparam int unsigned AW     = $clog2(MA),
  localparam int unsigned CW     = $clog2(DEGREE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_start_i,
  input  logic [1:0]            op_mode_i,
  input  logic [D_WIDTH-1:0]    modulus_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [D_WIDTH-1:0]    in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [D_WIDTH-1:0]    out_data_o,
  output logic                  out_last_o,
  output logic [BN-1:0]         mem_we_o,
  output logic                  mem_re_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [D_WIDTH-1:0]    mem_wdata_o,
  input  logic [BN*D_WIDTH-1:0] mem_rdata_i,
  output logic                  core_start_o,
  input  logic                  core_done_i,
  output logic                  busy_o,
  output logic                  op_done_o,
  output logic                  range_err_o
);

  localparam int unsigned CBW = $clog2(BN);

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [CW-1:0]      cnt_q;
  logic [AW-1:0]      row_q;
  logic [CBW-1:0]     col_q;
  logic               in_ready_q, out_valid_q, mem_re_q, core_start_q;
  logic               busy_q, op_done_q, range_err_q;
  logic [BN-1:0]      mem_we_q;
  logic [AW-1:0]      mem_addr_q;
  logic [D_WIDTH-1:0] mem_wdata_q;
  logic [D_WIDTH-1:0] buf_data;
  logic               in_hs, out_hs, capt;

  assign in_hs  = in_ready_q & in_valid_i;
  assign out_hs = out_valid_q & out_ready_i;
  assign capt   = (state_q == StCapt);

  ntt_row_buffer #(
    .D_WIDTH(D_WIDTH),
    .BN     (BN)
  ) u_row_buffer (
    .clk    (clk),
    .capt_i (capt),
    .rdata_i(mem_rdata_i),
    .col_i  (col_q),
    .data_o (buf_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= MODE_NOP;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      mem_re_q     <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      op_done_q    <= 1'b0;
      range_err_q  <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      core_start_q <= 1'b0;
      op_done_q    <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= '0;
      unique case (state_q)
        StIdle: begin
          if (op_start_i) begin
            mode_q      <= op_mode_i;
            range_err_q <= 1'b0;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b1;
            unique case (op_mode_i)
              MODE_LOAD, MODE_FULL: begin
                state_q    <= StLoad;
                in_ready_q <= 1'b1;
              end
              MODE_UNLOAD: begin
                state_q    <= StFetch;
                mem_re_q   <= 1'b1;
                mem_addr_q <= '0;
              end
              default: begin
                state_q   <= StFin;
                op_done_q <= 1'b1;
              end
            endcase
          end
        end
        StLoad: begin
          if (in_hs) begin
            mem_we_q    <= BN'(1) << cnt_q[CBW-1:0];
            mem_addr_q  <= cnt_q[CBW +: AW];
            mem_wdata_q <= in_data_i;
            cnt_q       <= cnt_q + 1'b1;
            if (in_data_i >= modulus_i) range_err_q <= 1'b1;
            if (cnt_q == CW'(DEGREE - 1)) in_ready_q <= 1'b0;
          end else if (!in_ready_q) begin
            // The last write is on the bus this cycle; leave only once it has issued.
            if (mode_q == MODE_FULL) begin
              state_q      <= StKick;
              core_start_q <= 1'b1;
            end else begin
              state_q   <= StFin;
              op_done_q <= 1'b1;
            end
          end
        end
        StKick: state_q <= StWait;
        StWait: begin
          if (core_done_i) begin
            state_q    <= StFetch;
            mem_re_q   <= 1'b1;
            mem_addr_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
          end
        end
        StFetch: state_q <= StCapt;
        StCapt: begin
          state_q     <= StEmit;
          out_valid_q <= 1'b1;
        end
        StEmit: begin
          if (out_hs) begin
            col_q <= col_q + 1'b1;
            if (col_q == CBW'(BN - 1)) begin
              out_valid_q <= 1'b0;
              if (row_q == AW'(MA - 1)) begin
                state_q   <= StFin;
                op_done_q <= 1'b1;
              end else begin
                state_q    <= StFetch;
                row_q      <= row_q + 1'b1;
                mem_re_q   <= 1'b1;
                mem_addr_q <= row_q + 1'b1;
              end
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_valid_q ? buf_data : '0;
  assign out_last_o   = out_valid_q && (row_q == AW'(MA - 1)) && (col_q == CBW'(BN - 1));
  assign mem_we_o     = mem_we_q;
  assign mem_re_o     = mem_re_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign core_start_o = core_start_q;
  assign busy_o       = busy_q;
  assign op_done_o    = op_done_q;
  assign range_err_o  = range_err_q;

endmodule

// File: doc/ntt_stream_loader.md
Name: ntt_stream_loader

Overview:
Streaming front-end that replaces backdoor preloading of the banked coefficient memory. It accepts DEGREE coefficients over a valid/ready stream and scatters them across BN banks. It then pulses the NTT core's start and waits for its done. Finally it reads the banked result back and streams it out in natural index order. Sits between the host/test stream and the existing memory and NTT core.

Parameters:
D_WIDTH, 17, coefficient width in bits (holds values mod 65537)
BN, 16, number of memory banks (power of two)
DEGREE, 256, polynomial length (multiple of BN)
MA, DEGREE/BN, derived localparam: rows per bank
AW, $clog2(MA), derived localparam: bank address width
CW, $clog2(DEGREE+1), derived localparam: beat counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
op_start  in  1  one-cycle command pulse; sampled only in IDLE
op_mode  in  2  01 load only, 10 unload only, 11 load+run+unload, 00 no-op
modulus  in  D_WIDTH  range bound for incoming coefficients
in_valid  in  1  input beat valid
in_ready  out  1  loader can accept a beat
in_data  in  D_WIDTH  input coefficient
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_data  out  D_WIDTH  output coefficient
out_last  out  1  marks beat DEGREE-1
mem_we  out  BN  one-hot bank write enable
mem_re  out  1  read all banks at mem_addr
mem_addr  out  AW  row address, shared by all banks
mem_wdata  out  D_WIDTH  write data, shared by all banks
mem_rdata  in  BN*D_WIDTH  bank b at bits [b*D_WIDTH +: D_WIDTH]; valid one cycle after mem_re
core_start  out  1  one-cycle start pulse to NTT core
core_done  in  1  NTT core completion (level or pulse)
busy  out  1  high outside IDLE
op_done  out  1  one-cycle pulse on return to IDLE
range_err  out  1  sticky; set when an accepted in_data >= modulus; cleared on op_start

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Counters 0. Row buffer contents don't-care. Asserting reset mid-operation aborts immediately. Memory contents are untouched.
- FSM states: IDLE, LOAD, KICK, WAIT, FETCH, CAPT, EMIT, FIN.
- IDLE: on op_start, op_mode 01/11 -> LOAD; 10 -> FETCH; 00 -> FIN. op_start in any other state is ignored.
- LOAD: in_ready=1. Each handshake at beat index i is registered, and one cycle later drives mem_we[i%BN]=1, mem_addr=i/BN, mem_wdata=in_data. Data is stored unmodified.
- LOAD exit: after the accept of i=DEGREE-1, in_ready drops the next cycle. Go to KICK if mode 11, else FIN (after the final write issues).
- KICK: core_start=1 for exactly one cycle -> WAIT.
- WAIT: remain until core_done=1 -> FETCH. A core_done seen in any other state is ignored.
- FETCH: mem_re=1, mem_addr=row -> CAPT.
- CAPT: latch mem_rdata into the BN-entry row buffer -> EMIT.
- EMIT: out_valid=1, out_data=buffer[col]. Hold steady while out_ready=0. On handshake col++.
- EMIT at col=BN-1 handshake: go to FETCH for row+1, or FIN if row=MA-1. out_last=1 on the beat for row=MA-1, col=BN-1.
- Throughput: 1 beat/cycle on load. On unload, BN beats per BN+2 cycles.
- FIN: op_done=1 for one cycle -> IDLE. busy=0 the cycle after FIN.
- Output index ordering: index = row*BN + col, matching the load mapping, so load-then-unload is an identity.
- in_valid outside LOAD is ignored and never accepted.

Decomposition:
- Shared package ntt_loader_pkg: the state enum and op_mode constants (MODE_LOAD, MODE_UNLOAD, MODE_FULL).
- One sub-module, ntt_row_buffer: the BN x D_WIDTH capture register with column select.
- FSM and counters live in the top module.

Test Plan:
- Mode 01, DEGREE=256, in_data=i with in_valid held high -> 256 writes; beat 17 gives mem_we=16'h0002, addr=1, wdata=17. op_done pulses once; range_err=0.
- Mode 11 with a stub core asserting core_done 20 cycles after core_start -> exactly one core_start pulse. Output stream equals the stub's bank contents in index order; out_last on beat 255 only.
- Mode 10 with random out_ready (50%) and banks preloaded with b*1000+addr -> out_data beat k = (k%16)*1000 + k/16. Data holds stable while stalled.
- Input data 65537 at beat 5 with modulus=65537 -> range_err=1 from the next cycle and stays set. Next op_start clears it.
- rst_n pulsed low during EMIT row 3 -> all outputs 0 asynchronously. A new mode-10 op restarts at beat 0.
- op_start during LOAD, and core_done pulsed during LOAD -> both ignored; beat count and single core_start unchanged.
